// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory-stage controller slice.
//   - control-bit indices into the E/M controlSignals bus
//   - memory-stage FSM state encoding
//   - default stack-pointer reset value (top of data memory)
package mem_pkg;

    localparam logic [15:0] SP_RESET_DEFAULT = 16'h07FF;

    localparam int unsigned CTL_MEM_READ  = 0;
    localparam int unsigned CTL_MEM_WRITE = 1;
    localparam int unsigned CTL_PUSH      = 2;
    localparam int unsigned CTL_POP       = 3;
    localparam int unsigned CTL_CALL      = 4;
    localparam int unsigned CTL_RET       = 5;
    localparam int unsigned CTL_REG_WRITE = 6;
    localparam int unsigned CTL_WB_LSB    = 7;
    localparam int unsigned CTL_WB_MSB    = 9;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CALL_LO  = 2'd1,
        ST_RET_HI   = 2'd2,
        ST_RET_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mem_stage_ctrl_sp_unit.sv
// sp_unit: stack pointer register with +/-1 and +/-2 update requests.
// Ports:
//   clk, rst            clock, asynchronous active-high reset (SP -> SP_RESET)
//   inc1/dec1/inc2/dec2 update requests; at most one is expected per cycle
//   sp                  current stack pointer
//   sp_plus1/sp_plus2   sp+1, sp+2 (modulo 2^16)
//   sp_minus1           sp-1 (modulo 2^16)
module sp_unit
    import mem_pkg::*;
#(
    parameter logic [15:0] SP_RESET = SP_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc1,
    input  logic        dec1,
    input  logic        inc2,
    input  logic        dec2,
    output logic [15:0] sp,
    output logic [15:0] sp_plus1,
    output logic [15:0] sp_plus2,
    output logic [15:0] sp_minus1
);

    logic [15:0] sp_q;

    assign sp        = sp_q;
    assign sp_plus1  = sp_q + 16'd1;
    assign sp_plus2  = sp_q + 16'd2;
    assign sp_minus1 = sp_q - 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q <= SP_RESET;
        end else if (inc1) begin
            sp_q <= sp_plus1;
        end else if (dec1) begin
            sp_q <= sp_minus1;
        end else if (inc2) begin
            sp_q <= sp_plus2;
        end else if (dec2) begin
            sp_q <= sp_q - 16'd2;
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory stage of the 16-bit pipeline.
// Drives the single-port data memory from the E/M register, produces the
// M/W write-back fields and owns the stack pointer. Single-cycle ops (load,
// store, push, pop, plain ALU write-back) finish in one cycle; call/interrupt
// (two writes) and ret (two reads) run a small FSM and raise stall.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   controlSignals_in     E/M control bus (see mem_pkg indices)
//   ALUData_in            ALU result / memory address
//   ReadData2_in          store/push data
//   WriteAdd_in           destination register
//   PC_in                 [31:0] return address, [47:32] not used here
//   interrupt             interrupt entry request
//   mem_rdata             memory read data, one cycle after mem_re
//   mem_addr/wdata/we/re  data memory port
//   stall                 hold E/M register and upstream stages
//   wb_en/addr/data/ctrl  M/W register inputs
//   pc_out, pc_load       popped return address and its load pulse
//   int_ack               interrupt return address saved
//   sp                    current stack pointer
module mem_stage_ctrl
    import mem_pkg::*;
#(
    parameter logic [15:0] SP_RESET = SP_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  controlSignals_in,
    input  logic [15:0] ALUData_in,
    input  logic [15:0] ReadData2_in,
    input  logic [2:0]  WriteAdd_in,
    input  logic [47:0] PC_in,
    input  logic        interrupt,
    input  logic [15:0] mem_rdata,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    output logic        stall,
    output logic        wb_en,
    output logic [2:0]  wb_addr,
    output logic [15:0] wb_data,
    output logic [2:0]  wb_ctrl,
    output logic [31:0] pc_out,
    output logic        pc_load,
    output logic        int_ack,
    output logic [15:0] sp
);

    state_t      state, state_nxt;
    logic        sp_inc1, sp_dec1, sp_inc2, sp_dec2;
    logic [15:0] sp_plus1, sp_plus2, sp_minus1;
    logic        single_done;
    logic        is_load;
    logic        load_pend;
    logic [15:0] wb_data_q;
    logic [15:0] ret_lo;
    logic        unused_pc_hi;

    assign unused_pc_hi = ^PC_in[47:32];

    sp_unit #(.SP_RESET(SP_RESET)) u_sp (
        .clk       (clk),
        .rst       (rst),
        .inc1      (sp_inc1),
        .dec1      (sp_dec1),
        .inc2      (sp_inc2),
        .dec2      (sp_dec2),
        .sp        (sp),
        .sp_plus1  (sp_plus1),
        .sp_plus2  (sp_plus2),
        .sp_minus1 (sp_minus1)
    );

    always_comb begin
        state_nxt   = state;
        mem_addr    = ALUData_in;
        mem_wdata   = ReadData2_in;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        stall       = 1'b0;
        sp_inc1     = 1'b0;
        sp_dec1     = 1'b0;
        sp_inc2     = 1'b0;
        sp_dec2     = 1'b0;
        single_done = 1'b0;
        is_load     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (interrupt || controlSignals_in[CTL_CALL]) begin
                    mem_we    = 1'b1;
                    mem_addr  = sp;
                    mem_wdata = PC_in[31:16];
                    stall     = 1'b1;
                    state_nxt = ST_CALL_LO;
                end else if (controlSignals_in[CTL_RET]) begin
                    mem_re    = 1'b1;
                    mem_addr  = sp_plus1;
                    stall     = 1'b1;
                    state_nxt = ST_RET_HI;
                end else begin
                    single_done = 1'b1;
                    if (controlSignals_in[CTL_PUSH]) begin
                        mem_we    = 1'b1;
                        mem_addr  = sp;
                        sp_dec1   = 1'b1;
                    end else if (controlSignals_in[CTL_POP]) begin
                        mem_re    = 1'b1;
                        mem_addr  = sp_plus1;
                        sp_inc1   = 1'b1;
                        is_load   = 1'b1;
                    end else if (controlSignals_in[CTL_MEM_WRITE]) begin
                        mem_we    = 1'b1;
                    end else if (controlSignals_in[CTL_MEM_READ]) begin
                        mem_re    = 1'b1;
                        is_load   = 1'b1;
                    end
                end
            end
            ST_CALL_LO: begin
                // E/M is still held, so PC_in carries the same return address.
                mem_we    = 1'b1;
                mem_addr  = sp_minus1;
                mem_wdata = PC_in[15:0];
                sp_dec2   = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_RET_HI: begin
                mem_re    = 1'b1;
                mem_addr  = sp_plus2;
                stall     = 1'b1;
                state_nxt = ST_RET_DONE;
            end
            ST_RET_DONE: begin
                sp_inc2   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (rst) begin
            mem_we = 1'b0;
            mem_re = 1'b0;
            stall  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            wb_en     <= 1'b0;
            wb_addr   <= '0;
            wb_data_q <= '0;
            wb_ctrl   <= '0;
            pc_load   <= 1'b0;
            int_ack   <= 1'b0;
            ret_lo    <= '0;
            load_pend <= 1'b0;
        end else begin
            state     <= state_nxt;
            wb_en     <= single_done & controlSignals_in[CTL_REG_WRITE];
            wb_addr   <= WriteAdd_in;
            wb_data_q <= ALUData_in;
            wb_ctrl   <= controlSignals_in[CTL_WB_MSB:CTL_WB_LSB];
            load_pend <= single_done & is_load;
            pc_load   <= (state == ST_RET_HI);
            int_ack   <= (state == ST_IDLE) & interrupt;
            // In RET_HI the read data is the low word fetched in the first ret cycle.
            if (state == ST_RET_HI) begin
                ret_lo <= mem_rdata;
            end
        end
    end

    // Load results arrive on mem_rdata in the write-back cycle, so they are
    // steered combinationally rather than registered a second time.
    assign wb_data = load_pend ? mem_rdata : wb_data_q;

    // High word is on mem_rdata in the cycle pc_load is high; pc_out is only
    // meaningful alongside pc_load.
    assign pc_out = {mem_rdata, ret_lo};

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

    localparam logic [9:0] C_MR   = 10'h001;
    localparam logic [9:0] C_MW   = 10'h002;
    localparam logic [9:0] C_PUSH = 10'h004;
    localparam logic [9:0] C_POP  = 10'h008;
    localparam logic [9:0] C_CALL = 10'h010;
    localparam logic [9:0] C_RET  = 10'h020;
    localparam logic [9:0] C_RW   = 10'h040;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  controlSignals_in = '0;
    logic [15:0] ALUData_in = '0;
    logic [15:0] ReadData2_in = '0;
    logic [2:0]  WriteAdd_in = '0;
    logic [47:0] PC_in = '0;
    logic        interrupt = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic [15:0] mem_addr, mem_wdata, wb_data, sp;
    logic        mem_we, mem_re, stall, wb_en, pc_load, int_ack;
    logic [2:0]  wb_addr, wb_ctrl;
    logic [31:0] pc_out;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem_model [0:65535];

    always #5 clk = ~clk;

    mem_stage_ctrl #(.SP_RESET(16'h07FF)) dut (
        .clk(clk), .rst(rst), .controlSignals_in(controlSignals_in),
        .ALUData_in(ALUData_in), .ReadData2_in(ReadData2_in),
        .WriteAdd_in(WriteAdd_in), .PC_in(PC_in), .interrupt(interrupt),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .stall(stall), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data), .wb_ctrl(wb_ctrl),
        .pc_out(pc_out), .pc_load(pc_load), .int_ack(int_ack), .sp(sp)
    );

    // Synchronous single-port data memory: read data one cycle after mem_re.
    always @(posedge clk) begin
        if (mem_we) mem_model[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem_model[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [9:0] c, input logic [15:0] a, input logic [15:0] d,
                          input logic [2:0] w, input logic [47:0] p, input logic irq);
        controlSignals_in = c;
        ALUData_in        = a;
        ReadData2_in      = d;
        WriteAdd_in       = w;
        PC_in             = p;
        interrupt         = irq;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(C_MW | C_RW, 16'h0010, 16'h1111, 3'd1, 48'h0, 1'b1);
        tick();
        tick();
        @(negedge clk);
        checks++; if (sp !== 16'h07FF) begin errors++; $display("FAIL reset_sp: got %h want 07ff", sp); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", mem_we); end
        checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL reset_re: got %b want 0", mem_re); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL reset_wb_en: got %b want 0", wb_en); end
        checks++; if (wb_data !== 16'h0000) begin errors++; $display("FAIL reset_wb_data: got %h want 0000", wb_data); end
        checks++; if (wb_ctrl !== 3'd0) begin errors++; $display("FAIL reset_wb_ctrl: got %h want 0", wb_ctrl); end
        checks++; if (pc_load !== 1'b0 || int_ack !== 1'b0) begin errors++; $display("FAIL reset_pulses: got pc_load=%b int_ack=%b want 0 0", pc_load, int_ack); end
        tick();
        set_in(10'h0, 16'h0, 16'h0, 3'd0, 48'h0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_store();
        set_in(C_MW | (10'd5 << 7), 16'h0010, 16'hBEEF, 3'd0, 48'h0, 1'b0);
        @(negedge clk);
        checks++; if (mem_we !== 1'b1 || mem_re !== 1'b0) begin errors++; $display("FAIL store_strobes: got we=%b re=%b want 1 0", mem_we, mem_re); end
        checks++; if (mem_addr !== 16'h0010) begin errors++; $display("FAIL store_addr: got %h want 0010", mem_addr); end
        checks++; if (mem_wdata !== 16'hBEEF) begin errors++; $display("FAIL store_wdata: got %h want beef", mem_wdata); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL store_stall: got %b want 0", stall); end
        tick();
        set_in(10'h0, 16'h0, 16'h0, 3'd0, 48'h0, 1'b0);
        @(negedge clk);
        checks++; if (wb_ctrl !== 3'd5) begin errors++; $display("FAIL store_wb_ctrl: got %0d want 5", wb_ctrl); end
        checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL store_wb_en: got %b want 0", wb_en); end
        tick();
    endtask

    task automatic test_push_pop();
        set_in(C_PUSH, 16'h0000, 16'h1234, 3'd0, 48'h0, 1'b0);
        @(negedge clk);
        checks++; if (mem_we !== 1'b1 || mem_addr !== 16'h07FF || mem_wdata !== 16'h1234) begin errors++; $display("FAIL push_write: got we=%b addr=%h wdata=%h want 1 07ff 1234", mem_we, mem_addr, mem_wdata); end
        tick();
        set_in(C_POP | C_RW, 16'h0000, 16'h0000, 3'd3, 48'h0, 1'b0);
        @(negedge clk);
        checks++; if (sp !== 16'h07FE) begin errors++; $display("FAIL push_sp: got %h want 07fe", sp); end
        checks++; if (mem_re !== 1'b1 || mem_addr !== 16'h07FF || stall !== 1'b0) begin errors++; $display("FAIL pop_read: got re=%b addr=%h stall=%b want 1 07ff 0", mem_re, mem_addr, stall); end
        tick();
        set_in(10'h0, 16'h0, 16'h0, 3'd0, 48'h0, 1'b0);
        @(negedge clk);
        checks++; if (sp !== 16'h07FF) begin errors++; $display("FAIL pop_sp: got %h want 07ff", sp); end
        checks++; if (wb_en !== 1'b1 || wb_addr !== 3'd3) begin errors++; $display("FAIL pop_wb_dest: got en=%b addr=%0d want 1 3", wb_en, wb_addr); end
        checks++; if (wb_data !== 16'h1234) begin errors++; $display("FAIL pop_wb_data: got %h want 1234", wb_data); end
        tick();
    endtask

    task automatic test_alu_wb();
        set_in(C_RW | (10'd3 << 7), 16'h5A5A, 16'h0000, 3'd5, 48'h0, 1'b0);
        @(negedge clk);
        checks++; if (mem_we !== 1'b0 || mem_re !== 1'b0) begin errors++; $display("FAIL alu_strobes: got we=%b re=%b want 0 0", mem_we, mem_re); end
        tick();
        set_in(10'h0, 16'h0, 16'h0, 3'd0, 48'h0, 1'b0);
        @(negedge clk);
        checks++; if (wb_en !== 1'b1 || wb_addr !== 3'd5 || wb_data !== 16'h5A5A || wb_ctrl !== 3'd3) begin errors++; $display("FAIL alu_wb: got en=%b addr=%0d data=%h ctrl=%0d want 1 5 5a5a 3", wb_en, wb_addr, wb_data, wb_ctrl); end
        tick();
    endtask

    task automatic test_load();
        set_in(C_MR | C_RW, 16'h0010, 16'h0000, 3'd2, 48'h0, 1'b0);
        @(negedge clk);
        checks++; if (mem_re !== 1'b1 || mem_addr !== 16'h0010 || stall !== 1'b0) begin errors++; $display("FAIL load_read: got re=%b addr=%h stall=%b want 1 0010 0", mem_re, mem_addr, stall); end
        tick();
        set_in(10'h0, 16'h0, 16'h0, 3'd0, 48'h0, 1'b0);
        @(negedge clk);
        checks++; if (wb_en !== 1'b1 || wb_addr !== 3'd2 || wb_data !== 16'hBEEF) begin errors++; $display("FAIL load_wb: got en=%b addr=%0d data=%h want 1 2 beef", wb_en, wb_addr, wb_data); end
        tick();
    endtask

    task automatic test_call();
        set_in(C_CALL | C_RW, 16'h0000, 16'h0000, 3'd4, 48'h0000_0001_0042, 1'b0);
        @(negedge clk);
        checks++; if (mem_we !== 1'b1 || mem_addr !== 16'h07FF || mem_wdata !== 16'h0001) begin errors++; $display("FAIL call_hi: got we=%b addr=%h wdata=%h want 1 07ff 0001", mem_we, mem_addr, mem_wdata); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL call_stall_t0: got %b want 1", stall); end
        tick();
        @(negedge clk);
        checks++; if (mem_we !== 1'b1 || mem_addr !== 16'h07FE || mem_wdata !== 16'h0042) begin errors++; $display("FAIL call_lo: got we=%b addr=%h wdata=%h want 1 07fe 0042", mem_we, mem_addr, mem_wdata); end
        checks++; if (stall !== 1'b0 || int_ack !== 1'b0 || wb_en !== 1'b0) begin errors++; $display("FAIL call_t1: got stall=%b int_ack=%b wb_en=%b want 0 0 0", stall, int_ack, wb_en); end
        checks++; if (sp !== 16'h07FF) begin errors++; $display("FAIL call_sp_t1: got %h want 07ff", sp); end
        tick();
        set_in(10'h0, 16'h0, 16'h0, 3'd0, 48'h0, 1'b0);
        @(negedge clk);
        checks++; if (sp !== 16'h07FD) begin errors++; $display("FAIL call_sp: got %h want 07fd", sp); end
        checks++; if (wb_en !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL call_done: got wb_en=%b stall=%b want 0 0", wb_en, stall); end
        tick();
    endtask

    task automatic test_ret();
        set_in(C_RET | C_RW, 16'h0000, 16'h0000, 3'd4, 48'h0, 1'b0);
        @(negedge clk);
        checks++; if (mem_re !== 1'b1 || mem_addr !== 16'h07FE || stall !== 1'b1) begin errors++; $display("FAIL ret_t0: got re=%b addr=%h stall=%b want 1 07fe 1", mem_re, mem_addr, stall); end
        tick();
        @(negedge clk);
        checks++; if (mem_re !== 1'b1 || mem_addr !== 16'h07FF || stall !== 1'b1) begin errors++; $display("FAIL ret_t1: got re=%b addr=%h stall=%b want 1 07ff 1", mem_re, mem_addr, stall); end
        checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL ret_t1_pc_load: got %b want 0", pc_load); end
        tick();
        @(negedge clk);
        checks++; if (stall !== 1'b0 || pc_load !== 1'b1 || mem_re !== 1'b0) begin errors++; $display("FAIL ret_t2: got stall=%b pc_load=%b re=%b want 0 1 0", stall, pc_load, mem_re); end
        checks++; if (pc_out !== 32'h0001_0042) begin errors++; $display("FAIL ret_pc_out: got %h want 00010042", pc_out); end
        checks++; if (sp !== 16'h07FD) begin errors++; $display("FAIL ret_sp_t2: got %h want 07fd", sp); end
        tick();
        set_in(10'h0, 16'h0, 16'h0, 3'd0, 48'h0, 1'b0);
        @(negedge clk);
        checks++; if (pc_load !== 1'b0 || wb_en !== 1'b0) begin errors++; $display("FAIL ret_after: got pc_load=%b wb_en=%b want 0 0", pc_load, wb_en); end
        checks++; if (sp !== 16'h07FF) begin errors++; $display("FAIL ret_sp: got %h want 07ff", sp); end
        tick();
    endtask

    task automatic test_int_priority();
        set_in(C_RET, 16'h0000, 16'h0000, 3'd0, 48'h0000_0002_0077, 1'b1);
        @(negedge clk);
        checks++; if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== 16'h07FF || mem_wdata !== 16'h0002) begin errors++; $display("FAIL int_t0: got we=%b re=%b addr=%h wdata=%h want 1 0 07ff 0002", mem_we, mem_re, mem_addr, mem_wdata); end
        checks++; if (stall !== 1'b1 || int_ack !== 1'b0) begin errors++; $display("FAIL int_t0_ctl: got stall=%b int_ack=%b want 1 0", stall, int_ack); end
        tick();
        @(negedge clk);
        checks++; if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== 16'h07FE || mem_wdata !== 16'h0077) begin errors++; $display("FAIL int_t1: got we=%b re=%b addr=%h wdata=%h want 1 0 07fe 0077", mem_we, mem_re, mem_addr, mem_wdata); end
        checks++; if (int_ack !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL int_ack: got int_ack=%b stall=%b want 1 0", int_ack, stall); end
        tick();
        set_in(10'h0, 16'h0, 16'h0, 3'd0, 48'h0, 1'b0);
        @(negedge clk);
        checks++; if (int_ack !== 1'b0 || sp !== 16'h07FD) begin errors++; $display("FAIL int_after: got int_ack=%b sp=%h want 0 07fd", int_ack, sp); end
        tick();
    endtask

    task automatic test_reset_mid_ret();
        set_in(C_RET, 16'h0000, 16'h0000, 3'd0, 48'h0, 1'b0);
        tick();
        @(negedge clk);
        checks++; if (stall !== 1'b1 || mem_addr !== 16'h07FF) begin errors++; $display("FAIL rmid_ret_hi: got stall=%b addr=%h want 1 07ff", stall, mem_addr); end
        rst = 1'b1;
        #1;
        checks++; if (stall !== 1'b0 || mem_re !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL rmid_outputs: got stall=%b re=%b we=%b want 0 0 0", stall, mem_re, mem_we); end
        checks++; if (sp !== 16'h07FF) begin errors++; $display("FAIL rmid_sp: got %h want 07ff", sp); end
        checks++; if (pc_load !== 1'b0 || wb_en !== 1'b0) begin errors++; $display("FAIL rmid_regs: got pc_load=%b wb_en=%b want 0 0", pc_load, wb_en); end
        tick();
        set_in(10'h0, 16'h0, 16'h0, 3'd0, 48'h0, 1'b0);
        checks++; if (pc_load !== 1'b0 || sp !== 16'h07FF) begin errors++; $display("FAIL rmid_held: got pc_load=%b sp=%h want 0 07ff", pc_load, sp); end
        rst = 1'b0;
        set_in(C_MR | C_RW, 16'h07FF, 16'h0000, 3'd6, 48'h0, 1'b0);
        @(negedge clk);
        checks++; if (mem_re !== 1'b1 || mem_addr !== 16'h07FF || stall !== 1'b0) begin errors++; $display("FAIL rmid_load: got re=%b addr=%h stall=%b want 1 07ff 0", mem_re, mem_addr, stall); end
        tick();
        set_in(10'h0, 16'h0, 16'h0, 3'd0, 48'h0, 1'b0);
        @(negedge clk);
        checks++; if (wb_en !== 1'b1 || wb_addr !== 3'd6 || wb_data !== 16'h0002) begin errors++; $display("FAIL rmid_load_wb: got en=%b addr=%0d data=%h want 1 6 0002", wb_en, wb_addr, wb_data); end
        checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL rmid_no_pc_load: got %b want 0", pc_load); end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem_model[i] = '0;
        test_reset();
        test_store();
        test_push_pop();
        test_alu_wb();
        test_load();
        test_call();
        test_ret();
        test_int_priority();
        test_reset_mid_ret();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller of the 16-bit pipeline: consumes the Execute/Memory pipeline register outputs, drives the single-port data memory, and produces write-back data for the Memory/Write-back register. Single-cycle ops (load, store, push, pop) complete in one cycle. Multi-word stack ops (call, return, interrupt entry) run a small FSM and assert `stall` so the Execute/Memory register holds its outputs until the op completes. Owns the stack pointer.

## Interface
- SP_RESET, 16'h07FF, stack pointer value after reset (top of data memory)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- controlSignals_in  in  10  from E/M register: [0] mem_read, [1] mem_write, [2] push, [3] pop, [4] call, [5] ret, [6] reg_write, [9:7] wb passthrough
- ALUData_in  in  16  ALU result / memory address
- ReadData2_in  in  16  store/push data
- WriteAdd_in  in  3  destination register
- PC_in  in  48  [31:0] return address; [47:32] unused here
- interrupt  in  1  interrupt entry request from E/M register
- mem_rdata  in  16  data memory read data, valid one cycle after mem_re
- mem_addr  out  16  data memory word address
- mem_wdata  out  16  data memory write data
- mem_we  out  1  write strobe
- mem_re  out  1  read strobe
- stall  out  1  hold E/M register and upstream stages
- wb_en  out  1  register write enable to M/W register
- wb_addr  out  3  destination register to M/W register
- wb_data  out  16  write-back data
- wb_ctrl  out  3  controlSignals_in[9:7], registered
- pc_out  out  32  return address popped by ret
- pc_load  out  1  one-cycle pulse: fetch loads pc_out
- int_ack  out  1  one-cycle pulse: interrupt return address saved
- sp  out  16  current stack pointer

## Operation
- Op select in IDLE, priority: interrupt > call > ret > push > pop > mem_write > mem_read; lower-priority bits ignored.
- LOAD: mem_re=1, mem_addr=ALUData_in; next cycle wb_data=mem_rdata.
- STORE: mem_we=1, mem_addr=ALUData_in, mem_wdata=ReadData2_in.
- PUSH: mem_we=1, mem_addr=SP, mem_wdata=ReadData2_in; SP←SP−1.
- POP: SP←SP+1; mem_re=1, mem_addr=SP+1; next cycle wb_data=mem_rdata.
- Other reg_write ops: wb_data=ALUData_in (registered).
- CALL / interrupt: write PC[31:16] at SP, then PC[15:0] at SP−1; SP←SP−2. Interrupt additionally pulses int_ack.
- RET: read SP+1 (low word), then SP+2 (high word); SP←SP+2; pc_out={high,low}, pc_load pulse.
- SP arithmetic modulo 2^16; wrap permitted, no flag.
- FSM states: IDLE, CALL_LO, RET_HI, RET_DONE.
  - IDLE→CALL_LO on call or interrupt.
  - IDLE→RET_HI on ret.
  - CALL_LO→IDLE.
  - RET_HI→RET_DONE.
  - RET_DONE→IDLE.
- wb_en = registered reg_write, captured only in the cycle an op completes. Never asserted for call, ret or interrupt.

## Timing
- Reset, asynchronous: state=IDLE, SP=SP_RESET. wb_en, wb_addr, wb_data, wb_ctrl, pc_load, int_ack all 0; low-word latch 0; load-pending flag 0.
- While rst high: mem_we, mem_re and stall forced 0.
- Reset mid-op aborts the op. No further memory access; SP=SP_RESET.
- Single-cycle ops: accepted in cycle T; stall=0; wb_* valid in T+1. For loads/pops, wb_data is driven from mem_rdata in T+1 (load-pending flag selects it).
- CALL/interrupt accepted at T:
  - T: write high word; stall=1.
  - T+1: write low word at SP−1; stall=0; SP updated at end of T+1; int_ack=1 in T+1.
- RET accepted at T:
  - T: read SP+1; stall=1.
  - T+1: read SP+2, latch low word; stall=1.
  - T+2: pc_out={mem_rdata, low}, pc_load=1, stall=0; SP updated at end of T+2.
- stall is combinational from state and inputs. It is high only in the listed cycles.
- New op accepted in the cycle after stall drops. Back-to-back single-cycle ops sustain one per cycle.

## Structure
- Shared package (mem_pkg): control-bit index constants, FSM state enum, SP_RESET default.
- One sub-module: sp_unit. Holds the SP register; inputs inc1/dec1/inc2/dec2; outputs sp, sp_plus1, sp_plus2, sp_minus1.

## Test plan
- Reset, then STORE ALUData=0x0010, ReadData2=0xBEEF → mem_we=1, addr 0x0010, wdata 0xBEEF, stall 0.
- PUSH 0x1234 then POP to R3 → writes mem[0x07FF]; sp 0x07FE then 0x07FF; POP reads 0x07FF; next cycle wb_en=1, wb_addr=3, wb_data=0x1234.
- CALL with PC=0x0001_0042 → 0x0001 written at 0x07FF, 0x0042 at 0x07FE; stall high exactly 1 cycle; sp=0x07FD; wb_en 0.
- RET after that CALL → reads 0x07FE then 0x07FF; stall 2 cycles; pc_out=0x0001_0042; pc_load one pulse; sp=0x07FF.
- interrupt and ret asserted together → interrupt wins; int_ack one pulse in second cycle; no reads issued.
- rst asserted in RET_HI → outputs zero at once; sp=0x07FF; following LOAD behaves normally.
